// File: rtl/axi4_lite_ram_arbiter_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) shared by the two requesters and the RAM slave port.
// The master modport is the side that issues requests; the slave modport answers them.
interface axi4_lite_ram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi4_lite_ram_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite RAM slave between two masters, one transaction
// at a time; write wins over read within a master, and channels route combinationally once granted.
module axi4_lite_ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axi4_lite_ram_arbiter_if.slave  m0,
  axi4_lite_ram_arbiter_if.slave  m1,
  axi4_lite_ram_arbiter_if.master s,
  output logic [1:0]              grant
);

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    GRANT_WR = 3'b010,
    GRANT_RD = 3'b100
  } state_t;

  state_t state;
  logic   owner;
  logic   last_owner;

  logic req0, req1, winner, winner_wr;

  logic [ADDR_WIDTH-1:0] sel_aw_addr, sel_ar_addr;
  logic [DATA_WIDTH-1:0] sel_w_data;
  logic                  sel_aw_valid, sel_w_valid, sel_b_ready, sel_ar_valid, sel_r_ready;

  // Tie goes to the master that did not finish the previous transaction.
  always_comb begin
    req0      = m0.aw_valid | m0.ar_valid;
    req1      = m1.aw_valid | m1.ar_valid;
    winner    = (req0 & req1) ? ~last_owner : req1;
    winner_wr = winner ? m1.aw_valid : m0.aw_valid;
  end

  assign sel_aw_addr  = owner ? m1.aw_addr  : m0.aw_addr;
  assign sel_aw_valid = owner ? m1.aw_valid : m0.aw_valid;
  assign sel_w_data   = owner ? m1.w_data   : m0.w_data;
  assign sel_w_valid  = owner ? m1.w_valid  : m0.w_valid;
  assign sel_b_ready  = owner ? m1.b_ready  : m0.b_ready;
  assign sel_ar_addr  = owner ? m1.ar_addr  : m0.ar_addr;
  assign sel_ar_valid = owner ? m1.ar_valid : m0.ar_valid;
  assign sel_r_ready  = owner ? m1.r_ready  : m0.r_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      grant      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner <= winner;
            state <= winner_wr ? GRANT_WR : GRANT_RD;
            grant <= winner ? 2'b10 : 2'b01;
          end
        end
        GRANT_WR: begin
          if (s.b_valid & sel_b_ready) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= owner;
          end
        end
        GRANT_RD: begin
          if (s.r_valid & sel_r_ready) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= owner;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    s.aw_addr   = '0;
    s.aw_valid  = 1'b0;
    s.w_data    = '0;
    s.w_valid   = 1'b0;
    s.b_ready   = 1'b0;
    s.ar_addr   = '0;
    s.ar_valid  = 1'b0;
    s.r_ready   = 1'b0;
    m0.aw_ready = 1'b0;
    m0.w_ready  = 1'b0;
    m0.b_resp   = '0;
    m0.b_valid  = 1'b0;
    m0.ar_ready = 1'b0;
    m0.r_data   = '0;
    m0.r_resp   = '0;
    m0.r_valid  = 1'b0;
    m1.aw_ready = 1'b0;
    m1.w_ready  = 1'b0;
    m1.b_resp   = '0;
    m1.b_valid  = 1'b0;
    m1.ar_ready = 1'b0;
    m1.r_data   = '0;
    m1.r_resp   = '0;
    m1.r_valid  = 1'b0;

    case (state)
      GRANT_WR: begin
        s.aw_addr  = sel_aw_addr;
        s.aw_valid = sel_aw_valid;
        s.w_data   = sel_w_data;
        s.w_valid  = sel_w_valid;
        s.b_ready  = sel_b_ready;
        if (owner) begin
          m1.aw_ready = s.aw_ready;
          m1.w_ready  = s.w_ready;
          m1.b_valid  = s.b_valid;
          m1.b_resp   = s.b_resp;
        end else begin
          m0.aw_ready = s.aw_ready;
          m0.w_ready  = s.w_ready;
          m0.b_valid  = s.b_valid;
          m0.b_resp   = s.b_resp;
        end
      end
      GRANT_RD: begin
        s.ar_addr  = sel_ar_addr;
        s.ar_valid = sel_ar_valid;
        s.r_ready  = sel_r_ready;
        if (owner) begin
          m1.ar_ready = s.ar_ready;
          m1.r_valid  = s.r_valid;
          m1.r_data   = s.r_data;
          m1.r_resp   = s.r_resp;
        end else begin
          m0.ar_ready = s.ar_ready;
          m0.r_valid  = s.r_valid;
          m0.r_data   = s.r_data;
          m0.r_resp   = s.r_resp;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_ram_arbiter.sv
// Bench for axi4_lite_ram_arbiter: two task-driven masters, a behavioural RAM slave,
// a reference memory and an expected grant order, checked with immediate assertions.
module tb_axi4_lite_ram_arbiter;
  localparam int DW     = 32;
  localparam int AW     = 10;
  localparam int BUDGET = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_bus ();
  axi4_lite_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_bus ();
  axi4_lite_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_bus ();
  logic [1:0] grant;

  axi4_lite_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .grant (grant)
  );

  int vectors = 0;
  int miscompares = 0;

  // Master-side drive, indexed by master number.
  logic [1:0]    mv_aw_valid = '0, mv_w_valid = '0, mv_b_ready = '0, mv_ar_valid = '0, mv_r_ready = '0;
  logic [AW-1:0] mv_aw_addr [2];
  logic [AW-1:0] mv_ar_addr [2];
  logic [DW-1:0] mv_w_data  [2];

  assign m0_bus.aw_valid = mv_aw_valid[0];
  assign m0_bus.aw_addr  = mv_aw_addr[0];
  assign m0_bus.w_valid  = mv_w_valid[0];
  assign m0_bus.w_data   = mv_w_data[0];
  assign m0_bus.b_ready  = mv_b_ready[0];
  assign m0_bus.ar_valid = mv_ar_valid[0];
  assign m0_bus.ar_addr  = mv_ar_addr[0];
  assign m0_bus.r_ready  = mv_r_ready[0];
  assign m1_bus.aw_valid = mv_aw_valid[1];
  assign m1_bus.aw_addr  = mv_aw_addr[1];
  assign m1_bus.w_valid  = mv_w_valid[1];
  assign m1_bus.w_data   = mv_w_data[1];
  assign m1_bus.b_ready  = mv_b_ready[1];
  assign m1_bus.ar_valid = mv_ar_valid[1];
  assign m1_bus.ar_addr  = mv_ar_addr[1];
  assign m1_bus.r_ready  = mv_r_ready[1];

  logic [1:0]    aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic [1:0]    b_resp_m [2];
  logic [1:0]    r_resp_m [2];
  logic [DW-1:0] r_data_m [2];
  assign aw_rdy = {m1_bus.aw_ready, m0_bus.aw_ready};
  assign w_rdy  = {m1_bus.w_ready,  m0_bus.w_ready};
  assign b_vld  = {m1_bus.b_valid,  m0_bus.b_valid};
  assign ar_rdy = {m1_bus.ar_ready, m0_bus.ar_ready};
  assign r_vld  = {m1_bus.r_valid,  m0_bus.r_valid};
  assign b_resp_m[0] = m0_bus.b_resp;
  assign b_resp_m[1] = m1_bus.b_resp;
  assign r_resp_m[0] = m0_bus.r_resp;
  assign r_resp_m[1] = m1_bus.r_resp;
  assign r_data_m[0] = m0_bus.r_data;
  assign r_data_m[1] = m1_bus.r_data;

  // Behavioural RAM slave: one-cycle ready pulse, response on the cycle after the handshake.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (!rst_n) begin
      s_bus.aw_ready <= 1'b0;
      s_bus.w_ready  <= 1'b0;
      s_bus.b_valid  <= 1'b0;
      s_bus.b_resp   <= 2'b00;
      s_bus.ar_ready <= 1'b0;
      s_bus.r_valid  <= 1'b0;
      s_bus.r_data   <= '0;
      s_bus.r_resp   <= 2'b00;
    end else begin
      s_bus.aw_ready <= 1'b0;
      s_bus.w_ready  <= 1'b0;
      s_bus.ar_ready <= 1'b0;
      if (s_bus.b_valid && s_bus.b_ready) s_bus.b_valid <= 1'b0;
      if (s_bus.r_valid && s_bus.r_ready) s_bus.r_valid <= 1'b0;
      if (s_bus.aw_valid && s_bus.aw_ready && s_bus.w_valid && s_bus.w_ready) begin
        ram[s_bus.aw_addr] <= s_bus.w_data;
        s_bus.b_valid      <= 1'b1;
        s_bus.b_resp       <= 2'b00;
      end else if (s_bus.aw_valid && s_bus.w_valid && !s_bus.aw_ready && !s_bus.b_valid) begin
        s_bus.aw_ready <= 1'b1;
        s_bus.w_ready  <= 1'b1;
      end
      if (s_bus.ar_valid && s_bus.ar_ready) begin
        s_bus.r_data  <= ram[s_bus.ar_addr];
        s_bus.r_valid <= 1'b1;
        s_bus.r_resp  <= 2'b00;
      end else if (s_bus.ar_valid && !s_bus.ar_ready && !s_bus.r_valid) begin
        s_bus.ar_ready <= 1'b1;
      end
    end
  end

  logic [DW-1:0] ref_mem [1024];
  logic [1:0]    exp_grants [$];
  logic [1:0]    grant_log [$];
  logic [1:0]    prev_grant = 2'b00;
  bit            mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Idle outputs must be zero; the non-owner must never see a valid or ready.
  always @(negedge clk) begin
    if (mon_en) begin
      if (grant !== prev_grant && grant !== 2'b00) grant_log.push_back(grant);
      prev_grant <= grant;
      if (grant === 2'b00) begin
        check("idle_s_ctrl", {s_bus.aw_valid, s_bus.w_valid, s_bus.b_ready, s_bus.ar_valid, s_bus.r_ready}, 64'd0);
        check("idle_s_addr_data", {s_bus.aw_addr, s_bus.ar_addr, s_bus.w_data}, 64'd0);
        check("idle_m_ctrl", {aw_rdy, w_rdy, b_vld, ar_rdy, r_vld}, 64'd0);
        check("idle_m_data", {r_data_m[1], r_data_m[0]}, 64'd0);
        check("idle_m_resp", {b_resp_m[1], b_resp_m[0], r_resp_m[1], r_resp_m[0]}, 64'd0);
      end else begin
        check("grant_onehot", 64'($onehot(grant)), 64'd1);
        if (grant === 2'b01)
          check("m1_nonowner_quiet", {aw_rdy[1], w_rdy[1], b_vld[1], ar_rdy[1], r_vld[1]}, 64'd0);
        else
          check("m0_nonowner_quiet", {aw_rdy[0], w_rdy[0], b_vld[0], ar_rdy[0], r_vld[0]}, 64'd0);
      end
    end
  end

  task automatic wr(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit       aw_done = 1'b0;
    bit       w_done = 1'b0;
    bit       b_done = 1'b0;
    logic [1:0] resp = 2'bxx;
    int       n = 0;
    mv_aw_addr[m] = a;
    mv_w_data[m]  = d;
    mv_aw_valid[m] = 1'b1;
    mv_w_valid[m]  = 1'b1;
    while (!(aw_done && w_done) && n < BUDGET) begin
      @(negedge clk);
      if (aw_rdy[m]) aw_done = 1'b1;
      if (w_rdy[m]) w_done = 1'b1;
      @(posedge clk); #1;
      if (aw_done) mv_aw_valid[m] = 1'b0;
      if (w_done) mv_w_valid[m] = 1'b0;
      n++;
    end
    mv_aw_valid[m] = 1'b0;
    mv_w_valid[m]  = 1'b0;
    mv_b_ready[m]  = 1'b1;
    n = 0;
    while (!b_done && n < BUDGET) begin
      @(negedge clk);
      if (b_vld[m]) begin
        b_done = 1'b1;
        resp   = b_resp_m[m];
      end
      @(posedge clk); #1;
      n++;
    end
    mv_b_ready[m] = 1'b0;
    check($sformatf("m%0d_aw_w_handshake", m), 64'(aw_done & w_done), 64'd1);
    check($sformatf("m%0d_b_handshake", m), 64'(b_done), 64'd1);
    check($sformatf("m%0d_b_resp", m), 64'(resp), 64'd0);
    ref_mem[a] = d;
  endtask

  task automatic rd(input int m, input logic [AW-1:0] a, output logic [DW-1:0] d);
    bit ar_done = 1'b0;
    bit r_done = 1'b0;
    logic [1:0] resp = 2'bxx;
    int n = 0;
    d = 'x;
    mv_ar_addr[m]  = a;
    mv_ar_valid[m] = 1'b1;
    while (!ar_done && n < BUDGET) begin
      @(negedge clk);
      if (ar_rdy[m]) ar_done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    mv_ar_valid[m] = 1'b0;
    mv_r_ready[m]  = 1'b1;
    n = 0;
    while (!r_done && n < BUDGET) begin
      @(negedge clk);
      if (r_vld[m]) begin
        r_done = 1'b1;
        d      = r_data_m[m];
        resp   = r_resp_m[m];
      end
      @(posedge clk); #1;
      n++;
    end
    mv_r_ready[m] = 1'b0;
    check($sformatf("m%0d_ar_handshake", m), 64'(ar_done), 64'd1);
    check($sformatf("m%0d_r_handshake", m), 64'(r_done), 64'd1);
    check($sformatf("m%0d_r_resp", m), 64'(resp), 64'd0);
  endtask

  task automatic check_grants(input string tag);
    logic [1:0] got;
    for (int i = 0; i < exp_grants.size(); i++) begin
      got = (i < grant_log.size()) ? grant_log[i] : 2'bxx;
      check($sformatf("%s_grant_%0d", tag, i), 64'(got), 64'(exp_grants[i]));
    end
    check($sformatf("%s_grant_count", tag), 64'(grant_log.size()), 64'(exp_grants.size()));
    exp_grants.delete();
    grant_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] pa [2][4];
    int            wait_n;

    for (int i = 0; i < 2; i++) begin
      mv_aw_addr[i] = '0;
      mv_ar_addr[i] = '0;
      mv_w_data[i]  = '0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_s_ctrl", {s_bus.aw_valid, s_bus.w_valid, s_bus.b_ready, s_bus.ar_valid, s_bus.r_ready}, 64'd0);
    check("rst_m_ctrl", {aw_rdy, w_rdy, b_vld, ar_rdy, r_vld}, 64'd0);

    // 1: single m0 write; one decision cycle, then forwarded unchanged.
    rst_n = 1'b1;
    mv_aw_addr[0] = 10'h004;
    mv_w_data[0]  = 32'hDEADBEEF;
    mv_aw_valid[0] = 1'b1;
    mv_w_valid[0]  = 1'b1;
    @(negedge clk);
    check("t1_decision_grant", 64'(grant), 64'd0);
    check("t1_decision_fwd", 64'(s_bus.aw_valid), 64'd0);
    @(negedge clk);
    check("t1_grant", 64'(grant), 64'b01);
    check("t1_s_aw", {s_bus.aw_valid, s_bus.w_valid, 20'h0, s_bus.aw_addr}, {2'b11, 20'h0, 10'h004});
    check("t1_s_wdata", 64'(s_bus.w_data), 64'hDEADBEEF);
    wr(0, 10'h004, 32'hDEADBEEF);
    exp_grants.push_back(2'b01);
    @(negedge clk);
    check("t1_grant_after_b", 64'(grant), 64'd0);
    check("t1_ram", 64'(ram[4]), 64'hDEADBEEF);

    // 2: m1 reads back what m0 wrote.
    rd(1, 10'h004, d);
    exp_grants.push_back(2'b10);
    check("t2_rdata", 64'(d), 64'hDEADBEEF);
    check_grants("t12");

    // 3: both write from the first cycle after reset; m0 wins the tie.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fork
      wr(0, 10'd1, 32'h11);
      wr(1, 10'd2, 32'h22);
    join
    exp_grants.push_back(2'b01);
    exp_grants.push_back(2'b10);
    check_grants("t3");
    check("t3_ram1", 64'(ram[1]), 64'h11);
    check("t3_ram2", 64'(ram[2]), 64'h22);

    // Preload random data, solo transactions alternating m0/m1 and ending on m1.
    for (int i = 0; i < 8; i++) begin
      pa[i % 2][i / 2] = AW'(16 + i * 100 + $urandom_range(0, 99));
      wr(i % 2, pa[i % 2][i / 2], $urandom);
      exp_grants.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
    end
    check_grants("preload");

    // 4: back-to-back reads from both masters alternate strictly, m0 first.
    fork
      begin
        logic [DW-1:0] d0;
        for (int k = 0; k < 4; k++) begin
          rd(0, pa[0][k], d0);
          check($sformatf("t4_m0_rdata_%0d", k), 64'(d0), 64'(ref_mem[pa[0][k]]));
        end
      end
      begin
        logic [DW-1:0] d1;
        for (int k = 0; k < 4; k++) begin
          rd(1, pa[1][k], d1);
          check($sformatf("t4_m1_rdata_%0d", k), 64'(d1), 64'(ref_mem[pa[1][k]]));
        end
      end
    join
    for (int k = 0; k < 4; k++) begin
      exp_grants.push_back(2'b01);
      exp_grants.push_back(2'b10);
    end
    check_grants("t4");

    // 5: m0 raises aw and ar together; the write is served first, AR stays blocked meanwhile.
    mv_ar_addr[0]  = 10'd3;
    mv_ar_valid[0] = 1'b1;
    mv_aw_addr[0]  = 10'd3;
    mv_w_data[0]   = 32'h55;
    mv_aw_valid[0] = 1'b1;
    mv_w_valid[0]  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_grant_wr", 64'(grant), 64'b01);
    check("t5_ar_blocked", {s_bus.ar_valid, ar_rdy[0], s_bus.aw_valid}, 64'b001);
    wr(0, 10'd3, 32'h55);
    rd(0, 10'd3, d);
    check("t5_rdata", 64'(d), 64'h55);
    exp_grants.push_back(2'b01);
    exp_grants.push_back(2'b01);
    check_grants("t5");

    // 6: reset while a read response is pending with r_ready low.
    mv_ar_addr[0]  = 10'd3;
    mv_ar_valid[0] = 1'b1;
    wait_n = 0;
    while (!(grant === 2'b01 && s_bus.r_valid === 1'b1) && wait_n < BUDGET) begin
      @(negedge clk);
      wait_n++;
    end
    check("t6_reached_pending_r", {grant, s_bus.r_valid, r_vld[0]}, {2'b01, 2'b11});
    @(posedge clk); #1;
    rst_n = 1'b0;
    mv_ar_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_grant", 64'(grant), 64'd0);
    check("t6_rst_ctrl", {r_vld[0], ar_rdy[0], s_bus.ar_valid, s_bus.r_ready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fork
      wr(0, 10'd5, 32'h0000_00A5);
      wr(1, 10'd6, 32'h0000_005A);
    join
    exp_grants.push_back(2'b01);
    exp_grants.push_back(2'b01);
    exp_grants.push_back(2'b10);
    check_grants("t6");
    check("t6_ram5", 64'(ram[5]), 64'hA5);
    check("t6_ram6", 64'(ram[6]), 64'h5A);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
